// File: rtl/ballot_input_controller.sv
// ballot_input_controller: synchronise and debounce four candidate buttons and accept one vote per armed ballot
module ballot_input_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic mode,
  input  logic ballot_enable,
  input  logic button1,
  input  logic button2,
  input  logic button3,
  input  logic button4,
  output logic valid_vote_1,
  output logic valid_vote_2,
  output logic valid_vote_3,
  output logic valid_vote_4,
  output logic ballot_armed,
  output logic invalid_press,
  output logic busy
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, LOCKOUT = 2'd3;
  logic [3:0] raw, s1, s2, db, sel, sel_n, vote_n;
  logic [DW-1:0] cnt [4];
  logic [1:0] state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [LW-1:0] lock, lock_n;
  logic inv_n, one_hot, multi, multi_seen;
  assign raw = {button4, button3, button2, button1};
  assign one_hot = db != 4'd0 && (db & (db - 4'd1)) == 4'd0;
  assign multi = db != 4'd0 && !one_hot;
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  // a level flips only after the synchronised value disagrees with it for a full run
  always_ff @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (reset) begin
        cnt[i] <= '0;
        db[i] <= 1'b0;
      end else if (s2[i] == db[i]) cnt[i] <= '0;
      else if (cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
        db[i] <= ~db[i];
        cnt[i] <= '0;
      end else cnt[i] <= cnt[i] + 1'b1;
  always_comb begin
    state_n = state;
    hold_n = hold;
    lock_n = lock;
    sel_n = sel;
    vote_n = '0;
    inv_n = 1'b0;
    case (state)
      IDLE: state_n = (ballot_enable && !mode) ? ARMED : IDLE;
      ARMED:
        if (mode) state_n = IDLE;
        else if (one_hot) begin
          sel_n = db;
          hold_n = '0;
          state_n = CAPTURE;
        end else inv_n = multi && !multi_seen;
      CAPTURE:
        if (mode) state_n = IDLE;
        else if (db != sel) begin
          inv_n = 1'b1;
          state_n = ARMED;
        end else if (hold == HW'(HOLD_CYCLES - 1)) begin
          vote_n = sel;
          lock_n = '0;
          state_n = LOCKOUT;
        end else hold_n = hold + 1'b1;
      default:
        if (lock == LW'(LOCKOUT_CYCLES) && db == 4'd0) state_n = IDLE;
        else if (lock != LW'(LOCKOUT_CYCLES)) lock_n = lock + 1'b1;
    endcase
  end
  // multi_seen survives a CAPTURE rejection so one multi-press event flags only once
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      lock <= '0;
      sel <= '0;
      multi_seen <= 1'b0;
      {valid_vote_4, valid_vote_3, valid_vote_2, valid_vote_1} <= '0;
      invalid_press <= 1'b0;
      ballot_armed <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      lock <= lock_n;
      sel <= sel_n;
      multi_seen <= multi && (state == ARMED || state == CAPTURE);
      {valid_vote_4, valid_vote_3, valid_vote_2, valid_vote_1} <= vote_n;
      invalid_press <= inv_n;
      ballot_armed <= state_n == ARMED || state_n == CAPTURE;
      busy <= state_n == CAPTURE || state_n == LOCKOUT;
    end
endmodule
